envelope_vca: RTL and testbench
===============================

// Module: envelope_vca
// PURPOSE
//  Amplitude stage between the 1-bit note oscillator and the board PWM pin. Turns the sequencer
//  gate into an attack/decay/sustain/release level and amplitude-modulates the square wave
//  with an 8-bit PWM carrier. Replaces the bare "osc & gate" AND at the output.
// PARAMETERS
//  ENV_BITS      8     envelope level and PWM counter width; MAX = 2**ENV_BITS-1
//  TICK_DIV      1024  clk cycles per envelope step (prescaler modulus, >=2)
//  ATTACK_STEP   8     level increment per tick in ATTACK
//  DECAY_STEP    2     level decrement per tick in DECAY
//  RELEASE_STEP  1     level decrement per tick in RELEASE
// PORTS
//  clk           in   1         system clock
//  rst           in   1         synchronous, active-high reset
//  gate          in   1         note on while high (from sequencer; held stable >=1 clk)
//  osc_in        in   1         square wave from the oscillator
//  sustain_level in   ENV_BITS  level held in SUSTAIN; sampled every clk
//  pwmout        out  1         modulated audio bit to pin, registered
//  env_level     out  ENV_BITS  current envelope level, registered
//  env_state     out  3         IDLE=0 ATTACK=1 DECAY=2 SUSTAIN=3 RELEASE=4
//  active        out  1         high whenever env_state != IDLE
// BEHAVIOUR
//  Reset: pwmout=0, env_level=0, env_state=IDLE, active=0, prescaler=0, pwm_cnt=0, gate_q=0.
//  Prescaler counts 0..TICK_DIV-1 and wraps; tick = 1-clk pulse when count==TICK_DIV-1.
//  gate_q <= gate each clk; rise = gate & ~gate_q; fall = ~gate & gate_q.
//  Gate events are evaluated every clk; level changes only on tick.
//  Priority each clk: rise > fall > tick step. An event cycle never also applies a step.
//  rise (any state incl. ATTACK) -> ATTACK, level kept (no snap to 0; retrigger is click-free).
//  fall in ATTACK/DECAY/SUSTAIN -> RELEASE, level kept. fall in IDLE/RELEASE: ignored.
//  ATTACK tick: sum = level+ATTACK_STEP in ENV_BITS+1 bits; sum>=MAX -> level=MAX, go DECAY.
//  DECAY tick: if level-DECAY_STEP <= sustain_level (signed compare, no wrap) -> level=
//   sustain_level, go SUSTAIN; else level-=DECAY_STEP. sustain_level=MAX: first tick -> SUSTAIN.
//  SUSTAIN: level follows sustain_level every clk (1-clk latency); stays until fall or rise.
//  RELEASE tick: if level<=RELEASE_STEP -> level=0, go IDLE; else level-=RELEASE_STEP.
//  IDLE: level held 0; only rise leaves it. gate high at reset release counts as a rise.
//  PWM: pwm_cnt free-running mod 2**ENV_BITS. pwmout <= osc_in & (pwm_cnt < env_level).
//   level 0 -> pwmout constantly 0; level MAX -> duty MAX/2**ENV_BITS. osc_in->pwmout 1 clk.
//  env_state/active/env_level update on the same clk edge; active is a decode of next state.
//  rst mid-note: all state cleared next edge; pwmout 0 the cycle after rst sampled high.
// TESTING (sim with TICK_DIV=4, default steps, ENV_BITS=8)
//  Reset with gate=1, osc_in=1 -> all outputs 0 while rst=1; after release rise seen, ATTACK,
//   level 8 after first tick, 16 after second.
//  Hold gate, sustain_level=100 -> level reaches 255 after 32 ticks (DECAY), then steps of 2
//   down to exactly 100, state SUSTAIN; change sustain_level to 60 -> level=60 next clk.
//  Drop gate in SUSTAIN at level 60 -> RELEASE, 60 ticks later level=0, IDLE, active=0.
//  Retrigger: gate low at level 40 in RELEASE, raise gate -> ATTACK from 40 (not 0), 48 next tick.
//  Gate fall coinciding with tick in ATTACK at level 16 -> RELEASE with level still 16 that clk.
//  PWM: osc_in=1, force level 64 -> pwmout high exactly 64 of every 256 clks; osc_in=0 -> always 0.

Source files
------------

// File: rtl/envelope_vca.sv
// ADSR envelope generator with PWM amplitude modulation of a 1-bit oscillator.
// The envelope steps on a prescaled tick; gate edges are acted on every clock.
module envelope_vca #(
    parameter int ENV_BITS     = 8,
    parameter int TICK_DIV     = 1024,
    parameter int ATTACK_STEP  = 8,
    parameter int DECAY_STEP   = 2,
    parameter int RELEASE_STEP = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                gate,
    input  logic                osc_in,
    input  logic [ENV_BITS-1:0] sustain_level,
    output logic                pwmout,
    output logic [ENV_BITS-1:0] env_level,
    output logic [2:0]          env_state,
    output logic                active
);

    localparam int PW  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int EW1 = ENV_BITS + 1;
    localparam int SW  = ENV_BITS + 2;

    localparam logic [PW-1:0]       PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [ENV_BITS-1:0] LVL_MAX    = {ENV_BITS{1'b1}};
    localparam logic [EW1-1:0]      ATK_STEP   = EW1'(ATTACK_STEP);
    localparam logic [ENV_BITS-1:0] DEC_STEP   = ENV_BITS'(DECAY_STEP);
    localparam logic [ENV_BITS-1:0] REL_STEP   = ENV_BITS'(RELEASE_STEP);
    localparam logic [SW-1:0]       DEC_STEP_W = SW'(DECAY_STEP);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_t;

    env_state_t          state_q,   state_d;
    logic [ENV_BITS-1:0] level_q,   level_d;
    logic [ENV_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PW-1:0]       presc_q,   presc_d;
    logic                gate_q,    gate_d;
    logic                active_q,  active_d;
    logic                pwmout_q,  pwmout_d;

    logic                tick_s;
    logic                rise_s;
    logic                fall_s;
    logic [EW1-1:0]      atk_sum_s;
    logic signed [SW-1:0] dec_diff_s;
    logic signed [SW-1:0] sus_wide_s;

    // Prescaler, gate edge detect, PWM carrier and modulated output.
    always_comb begin
        tick_s = (presc_q == PRESC_LAST);
        if (tick_s) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end
        gate_d    = gate;
        rise_s    = gate & ~gate_q;
        fall_s    = ~gate & gate_q;
        pwm_cnt_d = pwm_cnt_q + ENV_BITS'(1);
        pwmout_d  = osc_in & (pwm_cnt_q < level_q);
    end

    // Envelope state machine; gate events pre-empt the tick step in the same clock.
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        atk_sum_s  = {1'b0, level_q} + ATK_STEP;
        dec_diff_s = $signed({2'b00, level_q}) - $signed(DEC_STEP_W);
        sus_wide_s = $signed({2'b00, sustain_level});
        if (rise_s) begin
            state_d = ST_ATTACK;
        end else if (fall_s) begin
            if ((state_q == ST_ATTACK) || (state_q == ST_DECAY) || (state_q == ST_SUSTAIN)) begin
                state_d = ST_RELEASE;
            end else begin
                state_d = state_q;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    level_d = '0;
                end
                ST_ATTACK: begin
                    if (!tick_s) begin
                        level_d = level_q;
                    end else if (atk_sum_s >= {1'b0, LVL_MAX}) begin
                        level_d = LVL_MAX;
                        state_d = ST_DECAY;
                    end else begin
                        level_d = atk_sum_s[ENV_BITS-1:0];
                    end
                end
                ST_DECAY: begin
                    // Signed compare keeps a step below zero from wrapping past sustain.
                    if (!tick_s) begin
                        level_d = level_q;
                    end else if (dec_diff_s <= sus_wide_s) begin
                        level_d = sustain_level;
                        state_d = ST_SUSTAIN;
                    end else begin
                        level_d = level_q - DEC_STEP;
                    end
                end
                ST_SUSTAIN: begin
                    level_d = sustain_level;
                end
                ST_RELEASE: begin
                    if (!tick_s) begin
                        level_d = level_q;
                    end else if (level_q <= REL_STEP) begin
                        level_d = '0;
                        state_d = ST_IDLE;
                    end else begin
                        level_d = level_q - REL_STEP;
                    end
                end
                default: begin
                    level_d = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end
        active_d = (state_d != ST_IDLE);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            level_q   <= '0;
            pwm_cnt_q <= '0;
            presc_q   <= '0;
            gate_q    <= 1'b0;
            active_q  <= 1'b0;
            pwmout_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            pwm_cnt_q <= pwm_cnt_d;
            presc_q   <= presc_d;
            gate_q    <= gate_d;
            active_q  <= active_d;
            pwmout_q  <= pwmout_d;
        end
    end

    assign pwmout    = pwmout_q;
    assign env_level = level_q;
    assign env_state = state_q;
    assign active    = active_q;

endmodule

// File: tb/tb_envelope_vca.sv
// Directed bench for envelope_vca with TICK_DIV=4; expected values worked out by hand.
module tb_envelope_vca;

    logic       clk;
    logic       rst;
    logic       gate;
    logic       osc_in;
    logic [7:0] sustain_level;
    logic       pwmout;
    logic [7:0] env_level;
    logic [2:0] env_state;
    logic       active;

    int n_tests;
    int n_fail;
    int hi_cnt;

    envelope_vca #(
        .ENV_BITS    (8),
        .TICK_DIV    (4),
        .ATTACK_STEP (8),
        .DECAY_STEP  (2),
        .RELEASE_STEP(1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .gate         (gate),
        .osc_in       (osc_in),
        .sustain_level(sustain_level),
        .pwmout       (pwmout),
        .env_level    (env_level),
        .env_state    (env_state),
        .active       (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests = n_tests + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic count_high(input int n);
        hi_cnt = 0;
        for (int i = 0; i < n; i++) begin
            clocks(1);
            hi_cnt = hi_cnt + {31'd0, pwmout};
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        hi_cnt  = 0;
        rst = 1'b1; gate = 1'b1; osc_in = 1'b1; sustain_level = 8'd100;

        clocks(3);
        chk("rst_level",  env_level, 32'd0);
        chk("rst_state",  env_state, 32'd0);
        chk("rst_active", active,    32'd0);
        chk("rst_pwm",    pwmout,    32'd0);

        // gate already high at release counts as a rise
        rst = 1'b0;
        clocks(1);
        chk("rise_state",  env_state, 32'd1);
        chk("rise_level",  env_level, 32'd0);
        chk("rise_active", active,    32'd1);
        chk("lvl0_pwm",    pwmout,    32'd0);
        clocks(3);
        chk("atk_tick1", env_level, 32'd8);
        clocks(4);
        chk("atk_tick2", env_level, 32'd16);

        clocks(120);
        chk("atk_max_level", env_level, 32'd255);
        chk("atk_max_state", env_state, 32'd2);

        clocks(308);
        chk("dec_101_level", env_level, 32'd101);
        chk("dec_101_state", env_state, 32'd2);
        clocks(4);
        chk("sus_level", env_level, 32'd100);
        chk("sus_state", env_state, 32'd3);

        sustain_level = 8'd60;
        clocks(1);
        chk("sus_follow", env_level, 32'd60);

        gate = 1'b0;
        clocks(1);
        chk("fall_state", env_state, 32'd4);
        chk("fall_level", env_level, 32'd60);
        clocks(237);
        chk("rel_1_level", env_level, 32'd1);
        chk("rel_1_state", env_state, 32'd4);
        clocks(1);
        chk("rel_end_level",  env_level, 32'd0);
        chk("rel_end_state",  env_state, 32'd0);
        chk("rel_end_active", active,    32'd0);

        // climb to 40, release, then retrigger from 40
        gate = 1'b1;
        clocks(1);
        chk("re_rise_state", env_state, 32'd1);
        clocks(19);
        chk("re_atk40", env_level, 32'd40);
        gate = 1'b0;
        clocks(1);
        chk("re_rel_state", env_state, 32'd4);
        chk("re_rel_level", env_level, 32'd40);
        gate = 1'b1;
        clocks(1);
        chk("retrig_state", env_state, 32'd1);
        chk("retrig_level", env_level, 32'd40);
        clocks(2);
        chk("retrig_tick", env_level, 32'd48);

        rst = 1'b1;
        clocks(1);
        chk("midrst_level",  env_level, 32'd0);
        chk("midrst_state",  env_state, 32'd0);
        chk("midrst_active", active,    32'd0);
        chk("midrst_pwm",    pwmout,    32'd0);
        rst = 1'b0;
        clocks(1);
        chk("rise2_state", env_state, 32'd1);
        clocks(7);
        chk("rise2_level", env_level, 32'd16);
        clocks(3);
        // fall lands on the same edge as the tick
        gate = 1'b0;
        clocks(1);
        chk("fall_tick_state", env_state, 32'd4);
        chk("fall_tick_level", env_level, 32'd16);

        sustain_level = 8'd255;
        gate = 1'b1;
        clocks(200);
        chk("sus_max_state", env_state, 32'd3);
        chk("sus_max_level", env_level, 32'd255);
        count_high(256);
        chk("pwm_duty_255", hi_cnt, 32'd255);

        sustain_level = 8'd64;
        clocks(1);
        chk("sus64_level", env_level, 32'd64);
        count_high(256);
        chk("pwm_duty_64", hi_cnt, 32'd64);
        osc_in = 1'b0;
        count_high(256);
        chk("pwm_osc0", hi_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
